// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversampled SCL/SDA, START/STOP detection, address match,
// MSB-first byte reception with open-drain ACK/NACK and a valid/ready byte output.
// state    | meaning
// IDLE     | bus free or not addressed, waiting for START
// ADDR     | shifting address + R/W
// ADDR_ACK | driving address ACK through the 9th SCL clock
// DATA     | shifting a data byte
// DATA_ACK | ACK/NACK slot for the data byte
// IGNORE   | not for us or byte refused; wait for START/STOP
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b0001000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       selected,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_hist_q, scl_hist_d;
    logic sda_hist_q, sda_hist_d;

    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       match_q, match_d;
    logic       ack_pend_q, ack_pend_d;
    logic       sda_drive_q, sda_drive_d;
    logic       selected_q, selected_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       stop_det_q, stop_det_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall;
    logic       start_cond, stop_cond;
    logic [7:0] shift_next;

    // Input synchronisers plus one history stage for edge detection.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i2c_scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i2c_sda};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_hist_d = scl_s;
        sda_hist_d = sda_s;
        scl_rise   = scl_s & ~scl_hist_q;
        scl_fall   = ~scl_s & scl_hist_q;
        start_cond = sda_hist_q & ~sda_s & scl_s;
        stop_cond  = ~sda_hist_q & sda_s & scl_s;
        shift_next = {shift_q[6:0], sda_s};
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        match_d      = match_q;
        ack_pend_d   = ack_pend_q;
        sda_drive_d  = sda_drive_q;
        selected_d   = selected_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_overrun_d = 1'b0;
        stop_det_d   = 1'b0;

        // Bus conditions pre-empt any SCL edge seen in the same clk.
        if (stop_cond) begin
            state_d     = ST_IDLE;
            sda_drive_d = 1'b0;
            selected_d  = 1'b0;
            stop_det_d  = 1'b1;
        end else if (start_cond) begin
            state_d     = ST_ADDR;
            cnt_d       = 4'd0;
            sda_drive_d = 1'b0;
            selected_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_drive_d = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            match_d = (shift_next == {SLAVE_ADDR, 1'b0});
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (match_q) begin
                            sda_drive_d = 1'b1;
                            state_d     = ST_ADDR_ACK;
                        end else begin
                            state_d     = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_drive_d = 1'b0;
                        selected_d  = 1'b1;
                        cnt_d       = 4'd0;
                        state_d     = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            ack_pend_d = rx_ready;
                            if (rx_ready) begin
                                rx_data_d  = shift_next;
                                rx_valid_d = 1'b1;
                            end else begin
                                rx_overrun_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_drive_d = ack_pend_q;
                        state_d     = ST_DATA_ACK;
                    end
                end
                ST_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_drive_d = 1'b0;
                        if (ack_pend_q) begin
                            cnt_d   = 4'd0;
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_IGNORE: begin
                    sda_drive_d = 1'b0;
                end
                default: begin
                    sda_drive_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_hist_q   <= 1'b1;
            sda_hist_q   <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            shift_q      <= 8'd0;
            match_q      <= 1'b0;
            ack_pend_q   <= 1'b0;
            sda_drive_q  <= 1'b0;
            selected_q   <= 1'b0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            stop_det_q   <= 1'b0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_hist_q   <= scl_hist_d;
            sda_hist_q   <= sda_hist_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            match_q      <= match_d;
            ack_pend_q   <= ack_pend_d;
            sda_drive_q  <= sda_drive_d;
            selected_q   <= selected_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            stop_det_q   <= stop_det_d;
        end
    end

    // Open-drain: only ever pull low or float.
    assign i2c_sda    = sda_drive_q ? 1'b0 : 1'bz;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;
    assign selected   = selected_q;
    assign stop_det   = stop_det_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-level I2C master driving directed and random write
// transfers, checked against a transaction-level model of expected ACKs and bytes.
module tb_i2c_slave_rx;

    localparam int         Q    = 40;
    localparam logic [6:0] ADDR = 7'h08;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_overrun, selected, stop_det;
    wire        sda_bus;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_rx #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_scl    (scl),
        .i2c_sda    (sda_bus),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_overrun (rx_overrun),
        .selected   (selected),
        .stop_det   (stop_det)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int ovr_cnt = 0;
    int stop_cnt = 0;
    int both_cnt = 0;
    logic [7:0] model_rx = 8'h00;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) valid_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (rx_valid && rx_overrun) both_cnt++;
            if (stop_det) stop_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_bit(input bit b);
        m_sda_low = !b;
        #Q scl = 1'b1;
        #(2*Q) scl = 1'b0;
        #Q;
    endtask

    task automatic put_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
    endtask

    task automatic ack_bit(output bit acked);
        m_sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q acked = (sda_bus === 1'b0);
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic send_start();
        m_sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q m_sda_low = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic send_stop();
        m_sda_low = 1'b1;
        #Q scl = 1'b1;
        #Q m_sda_low = 1'b0;
        #Q;
    endtask

    // One complete write transfer; expectations come from the transaction rules:
    // address ACKed only for ADDR+W, each byte ACKed while accepted, first refusal
    // NACKs and silences the rest of the transfer.
    task automatic xfer(input logic [6:0] a, input bit rw, input int n,
                        input logic [31:0] d, input logic [3:0] rdy);
        bit acked, exp_sel, alive, exp_ack;
        int v0, o0, s0, exp_v, exp_o;
        logic [7:0] b;
        v0 = valid_cnt; o0 = ovr_cnt; s0 = stop_cnt; exp_v = 0; exp_o = 0;
        exp_sel = (a == ADDR) && !rw;
        send_start();
        put_byte({a, rw});
        ack_bit(acked);
        check("addr_ack", {31'b0, acked}, {31'b0, exp_sel});
        check("selected_after_addr", {31'b0, selected}, {31'b0, exp_sel});
        alive = exp_sel;
        for (int i = 0; i < n; i++) begin
            b = d[8*i +: 8];
            rx_ready = rdy[i];
            put_byte(b);
            exp_ack = alive && rdy[i];
            if (alive) begin
                if (rdy[i]) begin
                    exp_v++;
                    model_rx = b;
                end else begin
                    exp_o++;
                    alive = 1'b0;
                end
            end
            ack_bit(acked);
            check("data_ack", {31'b0, acked}, {31'b0, exp_ack});
        end
        rx_ready = 1'b1;
        send_stop();
        #(2*Q);
        check("valid_count", valid_cnt - v0, exp_v);
        check("overrun_count", ovr_cnt - o0, exp_o);
        check("rx_data", {24'b0, rx_data}, {24'b0, model_rx});
        check("stop_det_count", stop_cnt - s0, 1);
        check("selected_after_stop", {31'b0, selected}, 32'd0);
        check("valid_overrun_overlap", both_cnt, 0);
    endtask

    initial begin
        bit acked;
        int v0, s0;
        logic [6:0] a;
        bit rw;
        int n;
        logic [31:0] d;
        logic [3:0] rdy;

        // Reset with idle bus
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #5;
        check("reset_sda", {31'b0, sda_bus}, 32'd1);
        check("reset_rx_data", {24'b0, rx_data}, 32'd0);
        check("reset_pulses", {28'b0, rx_valid, rx_overrun, selected, stop_det}, 32'd0);
        reset = 1'b0;
        #(2*Q);

        // Directed transfers
        xfer(7'h08, 1'b0, 1, 32'h0000_00A5, 4'b0001);
        xfer(7'h09, 1'b0, 1, 32'h0000_0055, 4'b0001);
        xfer(7'h08, 1'b1, 1, 32'h0000_00C3, 4'b0001);
        xfer(7'h08, 1'b0, 3, 32'h0012_FF3C, 4'b0101);

        // Random transfers
        for (int t = 0; t < 20; t++) begin
            a  = ($urandom_range(0, 3) != 0) ? ADDR : 7'($urandom);
            rw = ($urandom_range(0, 4) == 0);
            n  = $urandom_range(1, 4);
            d  = $urandom;
            for (int i = 0; i < 4; i++) rdy[i] = ($urandom_range(0, 4) != 0);
            xfer(a, rw, n, d, rdy);
        end

        // Repeated START after 4 data bits discards the partial byte
        v0 = valid_cnt;
        send_start();
        put_byte({ADDR, 1'b0});
        ack_bit(acked);
        check("rs_addr_ack", {31'b0, acked}, 32'd1);
        check("rs_selected", {31'b0, selected}, 32'd1);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        send_start();
        check("rs_selected_cleared", {31'b0, selected}, 32'd0);
        put_byte({ADDR, 1'b0});
        ack_bit(acked);
        check("rs_readdr_ack", {31'b0, acked}, 32'd1);
        put_byte(8'h5A);
        ack_bit(acked);
        check("rs_data_ack", {31'b0, acked}, 32'd1);
        send_stop();
        #(2*Q);
        model_rx = 8'h5A;
        check("rs_valid_count", valid_cnt - v0, 1);
        check("rs_rx_data", {24'b0, rx_data}, {24'b0, model_rx});

        // Reset while the address ACK is being driven
        send_start();
        put_byte({ADDR, 1'b0});
        m_sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q;
        check("rst_ack_driven", {31'b0, sda_bus}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sda_released", {31'b0, sda_bus}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        model_rx = 8'h00;
        check("rst_rx_data", {24'b0, rx_data}, {24'b0, model_rx});
        #Q scl = 1'b0;
        #Q;
        v0 = valid_cnt; s0 = stop_cnt;
        put_byte(8'hC3);
        ack_bit(acked);
        check("rst_idle_nack", {31'b0, acked}, 32'd0);
        check("rst_idle_selected", {31'b0, selected}, 32'd0);
        send_stop();
        #(2*Q);
        check("rst_idle_valid", valid_cnt - v0, 0);
        check("rst_stop_det", stop_cnt - s0, 1);

        // Recovery after reset
        xfer(7'h08, 1'b0, 2, 32'h0000_7E81, 4'b0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- Write-only I2C target that sits directly downstream of the I2C master, on the shared i2c_scl/i2c_sda pair.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Shifts in the 7-bit address plus R/W bit, ACKs its own address, then receives data bytes MSB-first and ACKs each one.
- Delivers every received byte to local logic through a valid/ready handshake.

Parameters:
- SLAVE_ADDR, 7'b0001000, 7-bit address this target responds to.
- SYNC_STAGES, 2, flip-flop stages in the SCL/SDA input synchronisers (legal values ≥ 2).

Ports:
- clk  input  1  system clock; must be ≥ 8× the SCL frequency.
- reset  input  1  synchronous, active-high reset.
- i2c_scl  input  1  bus clock from the master.
- i2c_sda  inout  1  bus data; this block only ever drives 0 or z (open-drain).
- rx_ready  input  1  local logic can accept a byte.
- rx_data  output  8  last accepted data byte.
- rx_valid  output  1  one-clk pulse: rx_data has been updated.
- rx_overrun  output  1  one-clk pulse: a byte was dropped because rx_ready was low.
- selected  output  1  high from address ACK until STOP, repeated START or reset.
- stop_det  output  1  one-clk pulse on a STOP condition.

Behaviour:
- Reset (synchronous, active-high): clk and reset as the codebase names them.
  - State=IDLE, SDA drive released (z), rx_data=0, all other outputs 0, bit counter=0.
  - Reset asserted mid-ACK releases SDA on the next clk edge.
- Input path: SCL and SDA each pass through SYNC_STAGES flops, then one history flop.
  - scl_rise = sync 0→1; scl_fall = sync 1→0.
  - START = synced SDA 1→0 while synced SCL=1.
  - STOP = synced SDA 0→1 while synced SCL=1.
  - Detection latency is SYNC_STAGES+1 clk after the pin change.
- Sampling: SDA is sampled on scl_rise only; bits are shifted MSB first.
- Drive timing: SDA drive changes only on scl_fall (registered, one clk after the detect).
- START or STOP in any state overrides everything else in that clk.
  - START: go to ADDR, counter=0, selected=0.
  - STOP: go to IDLE, release SDA, selected=0, stop_det=1.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (addr[6:0], R/W).
    - On the 8th scl_rise, evaluate: match = (addr==SLAVE_ADDR && R/W==0).
    - On the next scl_fall: if match, drive SDA=0 and go to ADDR_ACK; otherwise keep SDA released and go to IGNORE.
  - ADDR_ACK: on scl_fall (end of the 9th clock), release SDA, set selected=1, counter=0, go to DATA.
  - DATA: shift 8 bits.
    - On the 8th scl_rise, if rx_ready=1: rx_data←shift value and rx_valid=1 (same clk), ACK pending.
    - If rx_ready=0: rx_data is unchanged, rx_overrun=1, NACK pending.
    - Next scl_fall: drive SDA=0 if ACK pending, then go to DATA_ACK.
  - DATA_ACK: on scl_fall, release SDA.
    - If the byte was ACKed, go to DATA with counter=0.
    - If NACKed, go to IGNORE.
  - IGNORE: SDA released; leave only via START or STOP.
- Simultaneous events: START/STOP detected in the same clk as an SCL edge — START/STOP wins and the SCL edge is discarded.
- rx_valid and rx_overrun are never high in the same clk.
- Counter is 4 bits and never wraps within a byte.
  - A 9th scl_rise in ADDR or DATA is impossible by construction; the ACK states consume it.
- No clock stretching. SCL is never driven.

Test Plan:
1. Reset held 3 clks with bus idle → i2c_sda=z, rx_data=0x00, rx_valid=rx_overrun=selected=stop_det=0.
2. START, addr 0x08, W, ACK, data 0xA5, STOP, with rx_ready=1 →
   - SDA=0 during both 9th clocks.
   - rx_valid one clk with rx_data=0xA5.
   - selected=1 after the address ACK.
   - stop_det pulse at STOP, then selected=0.
3. START, addr 0x09, W, data 0x55 → SDA never driven, no rx_valid, selected stays 0; a following STOP gives stop_det=1.
4. START, addr 0x08, R/W=1 → address NACKed (SDA=z on the 9th clock), state IGNORE until STOP.
5. Addr 0x08 W, then 0x3C with rx_ready=1, then 0xFF with rx_ready=0 →
   - 0x3C: ACK and rx_valid.
   - 0xFF: NACK and rx_overrun pulse; rx_data stays 0x3C.
   - Further SCL pulses are ignored until STOP.
6. Two cases:
   - Repeated START after 4 data bits → ADDR entered, partial byte discarded, selected=0.
   - reset asserted while SDA is driven low in ADDR_ACK → SDA=z one clk later, state IDLE.
